// File: rtl/tt_sum_engine.sv
// Parametrised add/subtract/accumulate engine with clock-enable rate divider,
// single-entry valid/ready output register and sticky overflow flag.
module tt_sum_engine #(
    parameter int W        = 8,
    parameter int GUARD    = 1,
    parameter int DIV_W    = 4,
    parameter int SATURATE = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_W-1:0]     cfg_div,
    input  logic [1:0]           mode,
    input  logic                 clear,
    input  logic [W-1:0]         a,
    input  logic [W-1:0]         b,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [W+GUARD-1:0]   out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 ovf
);

    localparam int OUT_W = W + GUARD;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0] acc_q, acc_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic [0:0]       state_q, state_d;
    logic             ovf_q, ovf_d;

    logic             tick;
    logic             accept;
    logic [OUT_W-1:0] a_ext, b_ext, acc_base;
    logic [OUT_W:0]   acc_sum;
    logic             carry;

    // >= rather than == so that lowering cfg_div below the count ticks at once
    assign tick      = (cnt_q >= cfg_div);
    assign in_ready  = tick & ((state_q == ST_EMPTY) | out_ready) & ~rst;
    assign accept    = in_valid & in_ready;
    assign out_data  = out_q;
    assign out_valid = (state_q == ST_FULL);
    assign ovf       = ovf_q;

    always_comb begin
        cnt_d    = tick ? '0 : cnt_q + DIV_W'(1);
        a_ext    = OUT_W'(a);
        b_ext    = OUT_W'(b);
        // clear takes effect before any accumulate in the same cycle
        acc_base = clear ? '0 : acc_q;
        acc_sum  = {1'b0, acc_base} + (OUT_W+1)'(a) + (OUT_W+1)'(b);
        carry    = acc_sum[OUT_W];

        acc_d    = acc_base;
        ovf_d    = clear ? 1'b0 : ovf_q;
        out_d    = out_q;

        if (accept) begin
            case (mode)
                2'b00: out_d = a_ext + b_ext;
                2'b01: out_d = a_ext - b_ext;
                2'b10: begin
                    if (carry && (SATURATE != 0)) begin
                        acc_d = '1;
                    end else begin
                        acc_d = acc_sum[OUT_W-1:0];
                    end
                    out_d = acc_d;
                    ovf_d = ovf_d | carry;
                end
                default: out_d = acc_base;
            endcase
        end

        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_FULL;
            default:  if (out_ready && !accept) state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            state_q <= ST_EMPTY;
            ovf_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            state_q <= state_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: doc/tt_sum_engine.md
Name: tt_sum_engine

Overview:
- Parametrised successor to the fixed 8-bit, divide-by-2 registered adder used in the project top.
- Computes add, subtract or accumulate on two W-bit operands at a programmable sample rate. The rate comes from an internal clock-enable divider; no derived clock is used.
- Results leave through a single-entry valid/ready output register, with a sticky overflow flag.
- Instantiated under the tt_um top and driven from ui_in/uio_in; its result drives uo_out/uio_out.

Parameters:
- W, 8, operand width in bits.
- GUARD, 1, extra result bits; OUT_W = W + GUARD.
- DIV_W, 4, width of the divider ratio input.
- SATURATE, 0, accumulate overflow handling: 1 = clamp at 2^OUT_W-1, 0 = wrap modulo 2^OUT_W.

Ports:
- clk  in  1  system clock; all flops on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_div  in  DIV_W  sample tick every cfg_div+1 clk cycles; 0 = every cycle.
- mode  in  2  00 add, 01 subtract, 10 accumulate, 11 accumulator readback; sampled with data.
- clear  in  1  synchronous accumulator/flag clear, level-sensitive per cycle.
- a  in  W  operand A.
- b  in  W  operand B.
- in_valid  in  1  operands valid.
- in_ready  out  1  block accepts operands this cycle.
- out_data  out  OUT_W  result.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer takes out_data.
- ovf  out  1  sticky overflow/saturation flag.

Behaviour:
- Reset (async, active-high): div counter=0, acc=0, out_data=0, out_valid=0, ovf=0; in_ready=0 while rst high.
- Divider:
  - Counter increments each clk.
  - When counter >= cfg_div: tick=1 that cycle and counter reloads to 0.
  - Lowering cfg_div below the current count produces a tick on the next cycle.
  - cfg_div=0 gives tick every cycle.
- in_ready = tick & (!out_valid | out_ready), combinational.
- Accept = in_valid & in_ready. Operands and mode are captured only on accept.
- Output FSM, states EMPTY (out_valid=0) and FULL (out_valid=1):
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on out_ready & !accept.
  - FULL stays FULL on out_ready & accept: new result replaces old in the same edge.
  - FULL with !out_ready: out_data held stable, no accept possible.
- Latency: result appears on out_data, with out_valid=1, at the clk edge after accept. Throughput is 1 per tick.
- Arithmetic (operands zero-extended to OUT_W):
  - 00 add: a+b. Always fits when GUARD>=1; no ovf.
  - 01 sub: (a-b) mod 2^OUT_W, two's complement. ovf unaffected.
  - 10 accumulate: acc_next = acc+a+b, computed at OUT_W+1 bits.
    - If carry: SATURATE=1 gives acc = 2^OUT_W-1; SATURATE=0 gives acc = low OUT_W bits. ovf set in both cases.
    - acc updated and out_data = acc_next.
  - 11 readback: out_data = acc; acc unchanged.
  - Modes 00/01 never modify acc.
- clear:
  - Without accept: acc=0 and ovf=0 at next edge; out_valid/out_data untouched.
  - With accept in mode 10: clear applied first, so acc = a+b, out_data = a+b, and ovf reflects only this operation.
  - With accept in mode 11: out_data=0.
- ovf clears only on rst or clear; it stays set across mode changes.
- Reset mid-operation: any pending result is discarded immediately (out_valid drops asynchronously); the divider restarts at 0.
- Changes to mode/a/b while not accepted have no effect.

Test Plan:
- W=8, GUARD=1, cfg_div=0, mode=00, a=200, b=100, out_ready=1 -> next cycle out_valid=1, out_data=9'h12C, ovf=0.
- mode=01, a=5, b=10 -> out_data=9'h1FB; acc and ovf unchanged.
- SATURATE=0, mode=10, (255,255) accepted twice -> out_data 510 then 508; ovf=1 after second. Then clear -> acc=0, ovf=0.
- SATURATE=1, same stimulus -> out_data 510 then 511, ovf=1. Then mode=11 -> out_data=511.
- cfg_div=3, in_valid held 1 -> in_ready high exactly 1 of every 4 cycles; results spaced 4 cycles.
- out_ready=0 with FULL: in_ready stays 0 and out_data stable for 10 cycles. Assert rst mid-stream -> out_valid=0, ovf=0, acc=0 immediately; first post-reset accumulate (3,4) -> out_data=7.
